led_counter_ctrl: RTL

//  Run/pause/step sequencer for the 4-bit LED counter on the iCEstick.

---
 rtl/led_counter_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/led_counter_ctrl.sv
// Run/pause/step sequencer for the 4-bit iCEstick LED counter with debounced buttons.
// Optional autostop (no wrap, done pulse) is enabled by defining LED_COUNTER_CTRL_AUTOSTOP_EN.
module led_counter_ctrl #(
   parameter int CLK_HZ          = 12000000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int WIDTH           = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_dir,
   output logic [WIDTH-1:0] led,
   output logic             running,
   output logic             tick,
   output logic             done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   logic             r_rst_meta, r_rst_sync;
   logic [2:0]       w_btn_raw;
   logic [2:0]       r_sync1, r_sync2, r_level;
   logic [1:0]       r_level_q;
   logic [CW-1:0]    r_db_cnt [3];
   logic             r_run_p, r_step_p;
   state_t           r_state;
   logic             r_running;
   logic [PW-1:0]    r_presc;
   logic [WIDTH-1:0] r_led;
   logic             w_dir, w_tick, w_block;
   logic [WIDTH-1:0] w_led_next;

   // Reset asserts immediately, releases on a clock edge to avoid recovery hazards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= 1'b1;
      end else begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_btn_raw = {btn_dir, btn_step, btn_run};

   always_ff @(posedge clk or posedge r_rst_sync) begin
      if (r_rst_sync) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level   <= '0;
         r_level_q <= '0;
         r_run_p   <= 1'b0;
         r_step_p  <= 1'b0;
         for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1   <= w_btn_raw;
         r_sync2   <= r_sync1;
         r_level_q <= r_level[1:0];
         r_run_p   <= r_level[0] & ~r_level_q[0];
         r_step_p  <= r_level[1] & ~r_level_q[1];
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_level[i]  <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_dir      = r_level[2];
   assign w_tick     = (r_state == S_RUN) && (r_presc == DIV_LAST);
   assign w_led_next = w_dir ? (r_led - WIDTH'(1)) : (r_led + WIDTH'(1));

`ifdef LED_COUNTER_CTRL_AUTOSTOP_EN
   logic r_done;
   assign w_block = w_dir ? (r_led == '0) : (r_led == '1);
   assign done    = r_done;
`else
   assign w_block = 1'b0;
   assign done    = 1'b0;
`endif

   always_ff @(posedge clk or posedge r_rst_sync) begin
      if (r_rst_sync) begin
         r_state   <= S_IDLE;
         r_running <= 1'b0;
         r_presc   <= '0;
         r_led     <= '0;
`ifdef LED_COUNTER_CTRL_AUTOSTOP_EN
         r_done    <= 1'b0;
`endif
      end else begin
`ifdef LED_COUNTER_CTRL_AUTOSTOP_EN
         r_done <= 1'b0;
`endif
         case (r_state)
            S_RUN: begin
               r_presc <= w_tick ? '0 : r_presc + PW'(1);
               // A suppressed wrap stops the run outright, overriding a coincident pause.
               if (w_tick && w_block) begin
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
`ifdef LED_COUNTER_CTRL_AUTOSTOP_EN
                  r_done    <= 1'b1;
`endif
               end else begin
                  if (w_tick) r_led <= w_led_next;
                  if (r_run_p) begin
                     r_state   <= S_PAUSE;
                     r_running <= 1'b0;
                  end
               end
            end
            default: begin
               if (r_run_p) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
                  r_presc   <= '0;
               end else if (r_step_p && !w_block) begin
                  r_led <= w_led_next;
`ifdef LED_COUNTER_CTRL_AUTOSTOP_EN
               end else if (r_step_p) begin
                  r_done <= 1'b1;
`endif
               end
            end
         endcase
      end
   end

   assign led     = r_led;
   assign running = r_running;
   assign tick    = w_tick;

endmodule
